// File: rtl/quad_threshold_if.sv
// quad_threshold_if: frame-analysis request, SRAM read port and quadrant threshold results
// Ports (slave = analyser side): i_start, i_begin_addr, i_data in; o_sram_addr, o_threshold1..4, o_finished out
interface quad_threshold_if;
    logic        i_start;
    logic [19:0] i_begin_addr;
    logic [15:0] i_data;
    logic [19:0] o_sram_addr;
    logic [7:0]  o_threshold1;
    logic [7:0]  o_threshold2;
    logic [7:0]  o_threshold3;
    logic [7:0]  o_threshold4;
    logic        o_finished;
    modport master (
        output i_start, i_begin_addr, i_data,
        input  o_sram_addr, o_threshold1, o_threshold2, o_threshold3, o_threshold4, o_finished
    );
    modport slave (
        input  i_start, i_begin_addr, i_data,
        output o_sram_addr, o_threshold1, o_threshold2, o_threshold3, o_threshold4, o_finished
    );
endinterface

// File: rtl/quad_threshold.sv
// quad_threshold: per-quadrant mean brightness of an SRAM frame, offset and clamped into four 8-bit thresholds
// Ports: i_clk, i_rst_n (async, active-low), bus (quad_threshold_if.slave: start/begin address/read data in,
//        read address, thresholds and finished flag out)
module quad_threshold #(
    parameter int ROWS       = 160,
    parameter int COLS       = 80,
    parameter int OFFSET     = 0,
    parameter int DEFAULT_TH = 128
) (
    input logic             i_clk,
    input logic             i_rst_n,
    quad_threshold_if.slave bus
);
    localparam int            RW     = $clog2(ROWS);
    localparam int            CW     = $clog2(COLS);
    localparam logic [RW-1:0] HALF_R = RW'(ROWS / 2);
    localparam logic [RW-1:0] LAST_R = RW'(ROWS - 1);
    localparam logic [CW-1:0] HALF_C = CW'(COLS / 2);
    localparam logic [CW-1:0] LAST_C = CW'(COLS - 1);
    localparam logic [22:0]   DIVISOR = 23'((ROWS / 2) * (COLS / 2) * 2);
    localparam logic [7:0]    DTH    = 8'(DEFAULT_TH);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIV} state_t;

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] word;
    logic [21:0]   sum [4];
    logic [21:0]   dq;
    logic [21:0]   rem;
    logic [4:0]    bit_i;
    logic [1:0]    quad;
    logic [7:0]    res [3];
    logic [1:0]    qsel;
    logic [8:0]    psum;
    logic [22:0]   trial;
    logic          ge;
    logic [21:0]   quo;

    function automatic logic [7:0] clamp(input logic [21:0] q);
        logic signed [23:0] v;
        v = $signed({2'b00, q}) + 24'(OFFSET);
        return v < 24'sd0 ? 8'd0 : (v > 24'sd255 ? 8'd255 : v[7:0]);
    endfunction

    // dq shifts the dividend out at the top while quotient bits enter at the bottom
    always_comb begin
        qsel  = {row >= HALF_R, word >= HALF_C};
        psum  = {1'b0, bus.i_data[15:8]} + {1'b0, bus.i_data[7:0]};
        trial = {rem, dq[21]};
        ge    = trial >= DIVISOR;
        quo   = {dq[20:0], ge};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= S_IDLE;
            row              <= '0;
            word             <= '0;
            sum              <= '{default: '0};
            dq               <= '0;
            rem              <= '0;
            bit_i            <= '0;
            quad             <= '0;
            res              <= '{default: '0};
            bus.o_sram_addr  <= '0;
            bus.o_finished   <= 1'b1;
            bus.o_threshold1 <= DTH;
            bus.o_threshold2 <= DTH;
            bus.o_threshold3 <= DTH;
            bus.o_threshold4 <= DTH;
        end else begin
            case (state)
                S_IDLE: if (bus.i_start) begin
                    state           <= S_ACCUM;
                    bus.o_sram_addr <= bus.i_begin_addr;
                    row             <= '0;
                    word            <= '0;
                    sum             <= '{default: '0};
                    bus.o_finished  <= 1'b0;
                end
                S_ACCUM: begin
                    sum[qsel]       <= sum[qsel] + 22'(psum);
                    bus.o_sram_addr <= bus.o_sram_addr + 20'd1;
                    word            <= word == LAST_C ? '0 : word + 1'b1;
                    if (word == LAST_C) row <= row + 1'b1;
                    // the last word always lands in quadrant 4, so quadrant 1 is final here
                    if (word == LAST_C && row == LAST_R) begin
                        state <= S_DIV;
                        dq    <= sum[0];
                        rem   <= '0;
                        bit_i <= '0;
                        quad  <= '0;
                    end
                end
                S_DIV: begin
                    rem   <= ge ? 22'(trial - DIVISOR) : trial[21:0];
                    dq    <= quo;
                    bit_i <= bit_i + 5'd1;
                    if (bit_i == 5'd21) begin
                        bit_i <= '0;
                        quad  <= quad + 2'd1;
                        dq    <= sum[quad + 2'd1];
                        rem   <= '0;
                        if (quad == 2'd3) begin
                            state            <= S_IDLE;
                            bus.o_finished   <= 1'b1;
                            bus.o_threshold1 <= res[0];
                            bus.o_threshold2 <= res[1];
                            bus.o_threshold3 <= res[2];
                            bus.o_threshold4 <= clamp(quo);
                        end else begin
                            res[quad] <= clamp(quo);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quad_threshold.sv
// tb_quad_threshold: directed frames against a pixel-level model of quadrant means, checked every cycle
module tb_quad_threshold;
    localparam int ROWS   = 160;
    localparam int COLS   = 80;
    localparam int OFFSET = 0;
    localparam int LAT    = 1 + ROWS * COLS + 88;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc   = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          pat   = 0;
    int          t0    = 0;
    logic [19:0] base  = '0;
    bit          chk_en = 1'b0;

    quad_threshold_if bus ();
    quad_threshold_if bus_a ();
    quad_threshold_if bus_b ();

    quad_threshold u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    quad_threshold #(.ROWS(4), .COLS(4), .OFFSET(20))  u_hi (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
    quad_threshold #(.ROWS(4), .COLS(4), .OFFSET(-20)) u_lo (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus_a.i_data = 16'hFAFA;
    assign bus_b.i_data = 16'h0505;

    // pattern 0 uniform 100; 1 quadrants 10/60/200/255; 2 Q1 alternating 0/1, Q2 37, Q3 0, Q4 171; 3 hi=row, lo=word
    function automatic logic [7:0] pix(int p, int r, int w, bit hi);
        bit rh = r >= ROWS / 2;
        bit wh = w >= COLS / 2;
        if (r < 0 || r >= ROWS) return 8'd0;
        case (p)
            0:       return 8'd100;
            1:       return rh ? (wh ? 8'd255 : 8'd200) : (wh ? 8'd60 : 8'd10);
            2:       return rh ? (wh ? 8'd171 : 8'd0) : (wh ? 8'd37 : (hi ? 8'd0 : 8'd1));
            default: return hi ? 8'(r) : 8'(w);
        endcase
    endfunction

    function automatic logic [31:0] frame_model(int p);
        longint      s [4];
        longint      v;
        logic [31:0] r;
        s = '{0, 0, 0, 0};
        r = '0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                s[(y >= ROWS / 2 ? 2 : 0) + (x >= COLS / 2 ? 1 : 0)] += longint'(pix(p, y, x, 1'b1)) + longint'(pix(p, y, x, 1'b0));
        for (int q = 0; q < 4; q++) begin
            v = s[q] / ((ROWS / 2) * (COLS / 2) * 2) + OFFSET;
            r[8*q +: 8] = v < 0 ? 8'd0 : (v > 255 ? 8'd255 : 8'(v));
        end
        return r;
    endfunction

    always_comb begin
        logic [19:0] off;
        off = bus.o_sram_addr - base;
        bus.i_data = {pix(pat, int'(off) / COLS, int'(off) % COLS, 1'b1), pix(pat, int'(off) / COLS, int'(off) % COLS, 1'b0)};
    end

    logic        m_fin;
    int          m_cnt;
    logic [31:0] m_th;
    logic [31:0] m_pend;
    logic [19:0] m_base;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fin <= 1'b1;
            m_cnt <= 0;
            m_th  <= {4{8'd128}};
        end else if (m_fin) begin
            if (bus.i_start) begin
                m_fin  <= 1'b0;
                m_cnt  <= 0;
                m_base <= bus.i_begin_addr;
                m_pend <= frame_model(pat);
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == LAT - 1) begin
                m_fin <= 1'b1;
                m_th  <= m_pend;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("finished", 32'(bus.o_finished), 32'(m_fin));
        chk("th1", 32'(bus.o_threshold1), 32'(m_th[7:0]));
        chk("th2", 32'(bus.o_threshold2), 32'(m_th[15:8]));
        chk("th3", 32'(bus.o_threshold3), 32'(m_th[23:16]));
        chk("th4", 32'(bus.o_threshold4), 32'(m_th[31:24]));
        if (!m_fin && m_cnt < ROWS * COLS)
            chk("sram_addr", 32'(bus.o_sram_addr), 32'(20'(m_base + 20'(m_cnt))));
    end

    task automatic start_main(int p, logic [19:0] b);
        #2;
        pat = p;
        base = b;
        bus.i_begin_addr = b;
        bus.i_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        #2 bus.i_start = 1'b0;
    endtask

    task automatic wait_main();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_finished && n < LAT + 100);
        chk("latency", 32'(cyc - t0), 32'd12889);
    endtask

    task automatic chk_th(string tag, int a, int b, int c, int d);
        chk({tag, "_th1"}, 32'(bus.o_threshold1), 32'(a));
        chk({tag, "_th2"}, 32'(bus.o_threshold2), 32'(b));
        chk({tag, "_th3"}, 32'(bus.o_threshold3), 32'(c));
        chk({tag, "_th4"}, 32'(bus.o_threshold4), 32'(d));
    endtask

    initial begin
        int n;
        bus.i_start = 1'b0;
        bus.i_begin_addr = '0;
        bus_a.i_start = 1'b0;
        bus_a.i_begin_addr = '0;
        bus_b.i_start = 1'b0;
        bus_b.i_begin_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_finished", 32'(bus.o_finished), 32'd1);
        chk("rst_addr", 32'(bus.o_sram_addr), 32'd0);
        chk_th("rst", 128, 128, 128, 128);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        @(negedge clk);
        #2 bus_a.i_start = 1'b1;
        bus_b.i_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        #2 bus_a.i_start = 1'b0;
        bus_b.i_start = 1'b0;
        n = 0;
        while (!(bus_a.o_finished && bus_b.o_finished) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("small_latency", 32'(cyc - t0), 32'd105);
        chk("offset_pos_th1", 32'(bus_a.o_threshold1), 32'd255);
        chk("offset_pos_th4", 32'(bus_a.o_threshold4), 32'd255);
        chk("offset_neg_th1", 32'(bus_b.o_threshold1), 32'd0);
        chk("offset_neg_th4", 32'(bus_b.o_threshold4), 32'd0);

        @(negedge clk);
        start_main(0, 20'h01000);
        repeat (498) @(negedge clk);
        #2 bus.i_start = 1'b1;
        @(negedge clk);
        chk("ignored_start", 32'(bus.o_finished), 32'd0);
        #2 bus.i_start = 1'b0;
        wait_main();
        chk_th("uniform100", 100, 100, 100, 100);

        start_main(1, 20'hFFF00);
        chk("b2b_started", 32'(bus.o_finished), 32'd0);
        wait_main();
        chk_th("quadrants", 10, 60, 200, 255);

        @(negedge clk);
        start_main(2, 20'h12345);
        wait_main();
        chk_th("truncate", 0, 37, 0, 171);

        @(negedge clk);
        start_main(1, 20'h00000);
        repeat (12840) @(negedge clk);
        chk("div_busy", 32'(bus.o_finished), 32'd0);
        chk_th("div_hold", 0, 37, 0, 171);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_finished", 32'(bus.o_finished), 32'd1);
        chk("abort_addr", 32'(bus.o_sram_addr), 32'd0);
        chk_th("abort", 128, 128, 128, 128);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        start_main(3, 20'h40000);
        wait_main();
        chk_th("gradient", 29, 49, 69, 89);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
